// File: rtl/stv_io_master.sv
// stv_io_master: bus initiator for the ST-V I/O chip register port.
// Runs single host read/write cycles and periodically polls ports A/B/C into shadow registers.
module stv_io_master #(
    parameter int unsigned SETUP_T     = 1,
    parameter int unsigned STROBE_T    = 2,
    parameter int unsigned HOLD_T      = 1,
    parameter logic [15:0] POLL_PERIOD = 16'd256
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce_r,
    // host side
    input  logic       i_req,
    input  logic       i_req_wr,
    input  logic [5:0] i_req_addr,
    input  logic [7:0] i_req_data,
    output logic       o_ack,
    output logic [7:0] o_rdata,
    output logic       o_busy,
    // autopoll
    input  logic       i_poll_en,
    output logic [7:0] o_poll_a,
    output logic [7:0] o_poll_b,
    output logic [7:0] o_poll_c,
    output logic       o_poll_valid,
    // I/O chip bus
    output logic [5:0] o_a,
    output logic [7:0] o_do,
    input  logic [7:0] i_di,
    output logic       o_cs_n,
    output logic       o_rw_n
);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_t;

    localparam logic [7:0] SetupLd  = 8'(SETUP_T - 1);
    localparam logic [7:0] StrobeLd = 8'(STROBE_T - 1);
    localparam logic [7:0] HoldLd   = 8'(HOLD_T - 1);

    // FSM
    state_t     r_state, w_state_d;
    logic [7:0] r_cnt, w_cnt_d;
    logic       w_start;
    logic       w_start_host;
    logic       w_last_strb;
    logic       w_done;

    // one-deep host request slot
    logic       r_pend_vld, w_pend_vld_d;
    logic       r_pend_wr;
    logic [5:0] r_pend_addr;
    logic [7:0] r_pend_data;
    logic       w_host_avail;
    logic       w_host_wr;
    logic [5:0] w_host_addr;
    logic [7:0] w_host_data;

    // attributes of the bus cycle in flight
    logic       r_cur_wr, w_cur_wr_d;
    logic       r_cur_host, w_cur_host_d;
    logic [5:0] r_cur_addr, w_cur_addr_d;
    logic [7:0] r_cur_data, w_cur_data_d;

    // poll timer and sequence
    logic [15:0] r_tmr;
    logic        w_wrap;
    logic        r_poll_act, w_poll_act_d;
    logic [1:0]  r_poll_idx, w_poll_idx_d;
    logic        w_poll_fin;
    logic [7:0]  r_tmp_a, r_tmp_b, r_tmp_c;
    logic [7:0]  r_cap;

    // registered outputs
    logic       r_cs_n, w_cs_n_d;
    logic       r_rw_n, w_rw_n_d;
    logic [5:0] r_a;
    logic [7:0] r_do;
    logic       r_ack;
    logic [7:0] r_rdata;
    logic       r_busy;
    logic [7:0] r_poll_a, r_poll_b, r_poll_c;
    logic       r_poll_valid;

    // An incoming REQ in IDLE with an empty slot is served directly, saving a cycle.
    assign w_host_avail = r_pend_vld | i_req;
    assign w_host_wr    = r_pend_vld ? r_pend_wr   : i_req_wr;
    assign w_host_addr  = r_pend_vld ? r_pend_addr : i_req_addr;
    assign w_host_data  = r_pend_vld ? r_pend_data : i_req_data;

    assign w_wrap     = i_ce_r && (r_tmr == POLL_PERIOD - 16'd1);
    assign w_poll_fin = w_done && !r_cur_host && (r_poll_idx == 2'd2);

    // Next-state: cycle phase sequencing with per-phase down-counter
    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_start      = 1'b0;
        w_start_host = 1'b0;
        w_last_strb  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            StIdle: begin
                // Host beats poll
                if (w_host_avail) begin
                    w_state_d    = StSetup;
                    w_cnt_d      = SetupLd;
                    w_start      = 1'b1;
                    w_start_host = 1'b1;
                end else if (r_poll_act) begin
                    w_state_d = StSetup;
                    w_cnt_d   = SetupLd;
                    w_start   = 1'b1;
                end
            end
            StSetup: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = StStrobe;
                    w_cnt_d   = StrobeLd;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StStrobe: begin
                if (r_cnt == 8'd0) begin
                    w_last_strb = 1'b1;
                    w_state_d   = StHold;
                    w_cnt_d     = HoldLd;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StHold: begin
                if (r_cnt == 8'd0) begin
                    w_done    = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Next-state: latch attributes of a newly started bus cycle
    always_comb begin
        w_cur_wr_d   = r_cur_wr;
        w_cur_host_d = r_cur_host;
        w_cur_addr_d = r_cur_addr;
        w_cur_data_d = r_cur_data;
        if (w_start_host) begin
            w_cur_wr_d   = w_host_wr;
            w_cur_host_d = 1'b1;
            w_cur_addr_d = w_host_addr;
            w_cur_data_d = w_host_data;
        end else if (w_start) begin
            // Ports A/B/C live at 0x01/0x03/0x05, i.e. A[6:1] = 0/1/2
            w_cur_wr_d   = 1'b0;
            w_cur_host_d = 1'b0;
            w_cur_addr_d = {4'b0000, r_poll_idx};
        end
    end

    // Next-state: bus strobes decoded from the upcoming phase and cycle direction
    always_comb begin
        w_cs_n_d = 1'b1;
        w_rw_n_d = 1'b1;
        case (w_state_d)
            StSetup, StHold: w_cs_n_d = !w_cur_wr_d;
            StStrobe: begin
                w_cs_n_d = 1'b0;
                w_rw_n_d = !w_cur_wr_d;
            end
            default: ;
        endcase
    end

    // Next-state: host slot fill/drain; a REQ into a full slot is dropped
    always_comb begin
        w_pend_vld_d = r_pend_vld;
        if (w_start_host) begin
            w_pend_vld_d = 1'b0;
        end else if (i_req && !r_pend_vld) begin
            w_pend_vld_d = 1'b1;
        end
    end

    // Next-state: poll sequence progress; timer ticks during a sequence are dropped
    always_comb begin
        w_poll_act_d = r_poll_act;
        w_poll_idx_d = r_poll_idx;
        if (w_done && !r_cur_host) begin
            if (r_poll_idx == 2'd2) begin
                w_poll_act_d = 1'b0;
                w_poll_idx_d = 2'd0;
            end else begin
                w_poll_idx_d = r_poll_idx + 2'd1;
            end
        end
        if (w_wrap && i_poll_en && !r_poll_act) begin
            w_poll_act_d = 1'b1;
            w_poll_idx_d = 2'd0;
        end
    end

    // FSM state, counter and in-flight cycle attributes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_cur_wr   <= 1'b0;
            r_cur_host <= 1'b0;
            r_cur_addr <= 6'd0;
            r_cur_data <= 8'd0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_cur_wr   <= w_cur_wr_d;
            r_cur_host <= w_cur_host_d;
            r_cur_addr <= w_cur_addr_d;
            r_cur_data <= w_cur_data_d;
        end
    end

    // Host request slot
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_wr   <= 1'b0;
            r_pend_addr <= 6'd0;
            r_pend_data <= 8'd0;
        end else begin
            r_pend_vld <= w_pend_vld_d;
            if (i_req && !r_pend_vld && !w_start_host) begin
                r_pend_wr   <= i_req_wr;
                r_pend_addr <= i_req_addr;
                r_pend_data <= i_req_data;
            end
        end
    end

    // Poll timer, sequence state and read-data capture on the last strobe cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmr      <= 16'd0;
            r_poll_act <= 1'b0;
            r_poll_idx <= 2'd0;
            r_tmp_a    <= 8'hFF;
            r_tmp_b    <= 8'hFF;
            r_tmp_c    <= 8'hFF;
            r_cap      <= 8'h00;
        end else begin
            if (i_ce_r) begin
                r_tmr <= w_wrap ? 16'd0 : r_tmr + 16'd1;
            end
            r_poll_act <= w_poll_act_d;
            r_poll_idx <= w_poll_idx_d;
            if (w_last_strb && !r_cur_wr) begin
                if (r_cur_host) begin
                    r_cap <= i_di;
                end else begin
                    case (r_poll_idx)
                        2'd0:    r_tmp_a <= i_di;
                        2'd1:    r_tmp_b <= i_di;
                        default: r_tmp_c <= i_di;
                    endcase
                end
            end
        end
    end

    // Registered bus and host-facing outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cs_n       <= 1'b1;
            r_rw_n       <= 1'b1;
            r_a          <= 6'd0;
            r_do         <= 8'hFF;
            r_ack        <= 1'b0;
            r_rdata      <= 8'h00;
            r_busy       <= 1'b0;
            r_poll_a     <= 8'hFF;
            r_poll_b     <= 8'hFF;
            r_poll_c     <= 8'hFF;
            r_poll_valid <= 1'b0;
        end else begin
            r_cs_n <= w_cs_n_d;
            r_rw_n <= w_rw_n_d;
            if (w_start) begin
                r_a <= w_cur_addr_d;
                if (w_cur_wr_d) begin
                    r_do <= w_cur_data_d;
                end
            end
            r_ack <= w_done && r_cur_host;
            if (w_done && r_cur_host && !r_cur_wr) begin
                r_rdata <= r_cap;
            end
            r_busy       <= (w_state_d != StIdle) || w_pend_vld_d || w_poll_act_d;
            r_poll_valid <= w_poll_fin;
            if (w_poll_fin) begin
                r_poll_a <= r_tmp_a;
                r_poll_b <= r_tmp_b;
                r_poll_c <= r_tmp_c;
            end
        end
    end

    assign o_cs_n       = r_cs_n;
    assign o_rw_n       = r_rw_n;
    assign o_a          = r_a;
    assign o_do         = r_do;
    assign o_ack        = r_ack;
    assign o_rdata      = r_rdata;
    assign o_busy       = r_busy;
    assign o_poll_a     = r_poll_a;
    assign o_poll_b     = r_poll_b;
    assign o_poll_c     = r_poll_c;
    assign o_poll_valid = r_poll_valid;

endmodule

// File: tb/tb_stv_io_master.sv
// Bench for stv_io_master: directed protocol scenarios plus randomized host/poll traffic
// checked against a register-file model of the I/O chip.
module tb_stv_io_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce_r = 1'b0;
    logic       req = 1'b0;
    logic       req_wr = 1'b0;
    logic [5:0] req_addr = 6'd0;
    logic [7:0] req_data = 8'd0;
    logic       ack;
    logic [7:0] rdata;
    logic       busy;
    logic       poll_en = 1'b0;
    logic [7:0] poll_a, poll_b, poll_c;
    logic       poll_valid;
    logic [5:0] a;
    logic [7:0] bus_do;
    logic [7:0] di = 8'h00;
    logic       cs_n, rw_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stv_io_master #(
        .SETUP_T    (1),
        .STROBE_T   (2),
        .HOLD_T     (1),
        .POLL_PERIOD(16'd4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ce_r      (ce_r),
        .i_req       (req),
        .i_req_wr    (req_wr),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_ack       (ack),
        .o_rdata     (rdata),
        .o_busy      (busy),
        .i_poll_en   (poll_en),
        .o_poll_a    (poll_a),
        .o_poll_b    (poll_b),
        .o_poll_c    (poll_c),
        .o_poll_valid(poll_valid),
        .o_a         (a),
        .o_do        (bus_do),
        .i_di        (di),
        .o_cs_n      (cs_n),
        .o_rw_n      (rw_n)
    );

    // I/O chip model: register file with registered read data, plus a backdoor write port
    logic [7:0] mem [64];
    logic       bd_we = 1'b0;
    logic [5:0] bd_a = 6'd0;
    logic [7:0] bd_d = 8'd0;
    always @(posedge clk) begin
        if (bd_we) mem[bd_a] <= bd_d;
        else if (!cs_n && !rw_n) mem[a] <= bus_do;
        if (!cs_n && rw_n) di <= mem[a];
    end

    // Transaction monitor: one entry per chip-select episode {write, addr, data}
    typedef struct packed {
        logic       wr;
        logic [5:0] ad;
        logic [7:0] d;
    } xact_t;
    xact_t      log_q[$];
    logic       mon_low = 1'b0;
    logic       mon_wr = 1'b0;
    logic [5:0] mon_a = 6'd0;
    logic [7:0] mon_d = 8'd0;
    int         ack_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            mon_low = 1'b0;
            mon_wr  = 1'b0;
        end else if (!cs_n) begin
            mon_low = 1'b1;
            mon_a   = a;
            if (!rw_n) begin
                mon_wr = 1'b1;
                mon_d  = bus_do;
            end else if (!mon_wr) begin
                mon_d = di;
            end
        end else if (mon_low) begin
            log_q.push_back({mon_wr, mon_a, mon_d});
            mon_low = 1'b0;
            mon_wr  = 1'b0;
        end
        if (ack) ack_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [5:0] ad, input logic [7:0] dv);
        bd_we = 1'b1;
        bd_a  = ad;
        bd_d  = dv;
        step();
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({cs_n, rw_n, ack, busy, poll_valid} !== 5'b11000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 11000", {cs_n, rw_n, ack, busy, poll_valid});
        end
        n_cmp++;
        if ({a, bus_do, rdata} !== {6'h00, 8'hFF, 8'h00}) begin
            n_err++;
            $display("FAIL reset_bus: got a=%h do=%h rdata=%h expected 00/FF/00", a, bus_do, rdata);
        end
        n_cmp++;
        if ({poll_a, poll_b, poll_c} !== 24'hFFFFFF) begin
            n_err++;
            $display("FAIL reset_shadow: got %h expected FFFFFF", {poll_a, poll_b, poll_c});
        end
        rst = 1'b0;
        step();
        step();
        n_cmp++;
        if ({cs_n, rw_n, ack, busy, poll_valid} !== 5'b11000) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b expected 11000", {cs_n, rw_n, ack, busy, poll_valid});
        end
    endtask

    // Shared timing trace for single host cycles from IDLE: expected {cs_n,rw_n,ack,busy}
    task automatic test_write();
        logic [3:0] exp_tr [6] = '{4'b0101, 4'b0001, 4'b0001, 4'b0101, 4'b1110, 4'b1100};
        poke(6'h03, 8'h00);
        req = 1'b1; req_wr = 1'b1; req_addr = 6'h03; req_data = 8'h5A;
        step();
        req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            n_cmp++;
            if ({cs_n, rw_n, ack, busy} !== exp_tr[c-1]) begin
                n_err++;
                $display("FAIL write_trace c%0d: got %b expected %b", c, {cs_n, rw_n, ack, busy}, exp_tr[c-1]);
            end
            if (c <= 4) begin
                n_cmp++;
                if ({a, bus_do} !== {6'h03, 8'h5A}) begin
                    n_err++;
                    $display("FAIL write_bus c%0d: got a=%h do=%h expected 03/5A", c, a, bus_do);
                end
            end
            step();
        end
        n_cmp++;
        if (mem[3] !== 8'h5A) begin
            n_err++;
            $display("FAIL write_effect: got %h expected 5A", mem[3]);
        end
    endtask

    task automatic test_read();
        logic [3:0] exp_tr [6] = '{4'b1101, 4'b0101, 4'b0101, 4'b1101, 4'b1110, 4'b1100};
        poke(6'h02, 8'hF3);
        req = 1'b1; req_wr = 1'b0; req_addr = 6'h02; req_data = 8'h00;
        step();
        req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            n_cmp++;
            if ({cs_n, rw_n, ack, busy} !== exp_tr[c-1]) begin
                n_err++;
                $display("FAIL read_trace c%0d: got %b expected %b", c, {cs_n, rw_n, ack, busy}, exp_tr[c-1]);
            end
            if (c <= 4) begin
                n_cmp++;
                if (a !== 6'h02) begin
                    n_err++;
                    $display("FAIL read_addr c%0d: got %h expected 02", c, a);
                end
            end
            if (c >= 5) begin
                n_cmp++;
                if (rdata !== 8'hF3) begin
                    n_err++;
                    $display("FAIL read_data c%0d: got %h expected F3", c, rdata);
                end
            end
            step();
        end
    endtask

    task automatic test_second_req_ignored();
        int    ack0;
        int    bound;
        xact_t exp_q[$];
        xact_t got;
        logic [7:0] d1, d2, d3, d0;
        d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
        d0 = ~d3;
        poke(6'h07, d0);
        log_q.delete();
        ack0 = ack_cnt;
        req = 1'b1; req_wr = 1'b1; req_addr = 6'h05; req_data = d1;
        step();
        req_addr = 6'h06; req_data = d2;
        step();
        req_addr = 6'h07; req_data = d3;
        step();
        req = 1'b0;
        bound = 0;
        while (busy && bound < 40) begin
            step();
            bound++;
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL second_req_idle: got busy=%b expected 0", busy);
        end
        n_cmp++;
        if (ack_cnt - ack0 != 2) begin
            n_err++;
            $display("FAIL second_req_acks: got %0d expected 2", ack_cnt - ack0);
        end
        exp_q.push_back({1'b1, 6'h05, d1});
        exp_q.push_back({1'b1, 6'h06, d2});
        n_cmp++;
        if (log_q.size() != 2) begin
            n_err++;
            $display("FAIL second_req_count: got %0d cycles expected 2", log_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL second_req_xact%0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (mem[7] !== d0) begin
            n_err++;
            $display("FAIL second_req_dropped: got reg7=%h expected %h", mem[7], d0);
        end
    endtask

    task automatic test_autopoll();
        logic [7:0] pa, pb, pc;
        int    bound;
        int    pulses;
        xact_t exp_q[$];
        xact_t got;
        pa = 8'h7E; pb = 8'hBD; pc = 8'hDB;
        poke(6'h00, pa);
        poke(6'h01, pb);
        poke(6'h02, pc);
        log_q.delete();
        ce_r = 1'b1;
        poll_en = 1'b1;
        bound = 0;
        while (poll_valid !== 1'b1 && bound < 60) begin
            step();
            bound++;
        end
        poll_en = 1'b0;
        n_cmp++;
        if (poll_valid !== 1'b1) begin
            n_err++;
            $display("FAIL autopoll_pulse: got no POLL_VALID expected pulse within 60 cycles");
        end
        n_cmp++;
        if ({poll_a, poll_b, poll_c} !== {pa, pb, pc}) begin
            n_err++;
            $display("FAIL autopoll_shadow: got %h expected %h", {poll_a, poll_b, poll_c}, {pa, pb, pc});
        end
        exp_q.push_back({1'b0, 6'h00, pa});
        exp_q.push_back({1'b0, 6'h01, pb});
        exp_q.push_back({1'b0, 6'h02, pc});
        n_cmp++;
        if (log_q.size() != 3) begin
            n_err++;
            $display("FAIL autopoll_count: got %0d cycles expected 3", log_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL autopoll_xact%0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (poll_valid) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL autopoll_single: got %0d extra pulses busy=%b expected 0/0", pulses, busy);
        end
    endtask

    task automatic test_host_during_poll();
        logic [7:0] pa, pb, pc, hd;
        int    bound;
        int    ack0;
        int    pulses;
        xact_t exp_q[$];
        xact_t got;
        pa = 8'($urandom); pb = 8'($urandom); pc = 8'($urandom); hd = 8'($urandom);
        poke(6'h00, pa);
        poke(6'h01, pb);
        poke(6'h02, pc);
        ce_r = 1'b1;
        poll_en = 1'b1;
        bound = 0;
        while (poll_valid !== 1'b1 && bound < 60) begin
            step();
            bound++;
        end
        log_q.delete();
        ack0 = ack_cnt;
        bound = 0;
        while (!(cs_n === 1'b0 && rw_n === 1'b1 && a === 6'h01) && bound < 60) begin
            step();
            bound++;
        end
        n_cmp++;
        if (bound >= 60) begin
            n_err++;
            $display("FAIL hdp_portb_strobe: got timeout expected port B strobe");
        end
        req = 1'b1; req_wr = 1'b1; req_addr = 6'h10; req_data = hd;
        step();
        req = 1'b0;
        pulses = 0;
        bound = 0;
        while (poll_valid !== 1'b1 && bound < 60) begin
            step();
            bound++;
        end
        if (poll_valid === 1'b1) pulses++;
        poll_en = 1'b0;
        n_cmp++;
        if ({poll_a, poll_b, poll_c} !== {pa, pb, pc}) begin
            n_err++;
            $display("FAIL hdp_shadow: got %h expected %h", {poll_a, poll_b, poll_c}, {pa, pb, pc});
        end
        exp_q.push_back({1'b0, 6'h00, pa});
        exp_q.push_back({1'b0, 6'h01, pb});
        exp_q.push_back({1'b1, 6'h10, hd});
        exp_q.push_back({1'b0, 6'h02, pc});
        n_cmp++;
        if (log_q.size() != 4) begin
            n_err++;
            $display("FAIL hdp_count: got %0d cycles expected 4", log_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL hdp_xact%0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (poll_valid) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || ack_cnt - ack0 != 1) begin
            n_err++;
            $display("FAIL hdp_pulse_ack: got pulses=%0d acks=%0d expected 1/1", pulses, ack_cnt - ack0);
        end
        n_cmp++;
        if (mem[6'h10] !== hd) begin
            n_err++;
            $display("FAIL hdp_write: got %h expected %h", mem[6'h10], hd);
        end
    endtask

    task automatic test_reset_mid_strobe();
        int ack0;
        int bound;
        ce_r = 1'b0;
        poke(6'h08, 8'h11);
        req = 1'b1; req_wr = 1'b1; req_addr = 6'h08; req_data = 8'hAA;
        step();
        req = 1'b0;
        step();
        n_cmp++;
        if ({cs_n, rw_n} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_pre_strobe: got %b expected 00", {cs_n, rw_n});
        end
        ack0 = ack_cnt;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cs_n, rw_n, busy} !== 3'b110) begin
            n_err++;
            $display("FAIL rst_async: got %b expected 110", {cs_n, rw_n, busy});
        end
        step();
        step();
        #2 rst = 1'b0;
        step();
        step();
        n_cmp++;
        if ({poll_a, poll_b, poll_c, bus_do} !== 32'hFFFFFFFF) begin
            n_err++;
            $display("FAIL rst_shadow: got %h expected FFFFFFFF", {poll_a, poll_b, poll_c, bus_do});
        end
        n_cmp++;
        if (ack_cnt != ack0 || mem[8] !== 8'h11) begin
            n_err++;
            $display("FAIL rst_abort: got acks=%0d reg8=%h expected 0/11", ack_cnt - ack0, mem[8]);
        end
        req = 1'b1; req_wr = 1'b1; req_addr = 6'h08; req_data = 8'h55;
        step();
        req = 1'b0;
        bound = 1;
        while (ack !== 1'b1 && bound < 20) begin
            step();
            bound++;
        end
        n_cmp++;
        if (bound != 5) begin
            n_err++;
            $display("FAIL rst_recover_latency: got %0d expected 5", bound);
        end
        n_cmp++;
        if (mem[8] !== 8'h55) begin
            n_err++;
            $display("FAIL rst_recover_write: got %h expected 55", mem[8]);
        end
    endtask

    // Random host traffic with poll enabled at random; the model is a plain register array
    task automatic test_random();
        logic [7:0] ref_mem [64];
        logic [5:0] wr_list[$];
        logic [5:0] ad;
        logic [7:0] dv;
        logic       wr;
        logic       idle0;
        int         lat;
        int         bound;
        poll_en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            dv = 8'($urandom);
            ref_mem[p] = dv;
            poke(6'(p), dv);
            wr_list.push_back(6'(p));
        end
        for (int i = 0; i < 40; i++) begin
            poll_en = 1'($urandom_range(0, 1));
            wr = (wr_list.size() <= 3) || ($urandom_range(0, 1) == 1);
            if (wr) begin
                ad = 6'($urandom_range(3, 63));
                dv = 8'($urandom);
            end else begin
                ad = wr_list[$urandom_range(0, wr_list.size() - 1)];
                dv = 8'($urandom);
            end
            idle0 = !busy;
            req = 1'b1; req_wr = wr; req_addr = ad; req_data = dv;
            ce_r = 1'($urandom_range(0, 1));
            step();
            req = 1'b0;
            lat = 1;
            while (ack !== 1'b1 && lat < 60) begin
                if (poll_valid === 1'b1) begin
                    n_cmp++;
                    if ({poll_a, poll_b, poll_c} !== {ref_mem[0], ref_mem[1], ref_mem[2]}) begin
                        n_err++;
                        $display("FAIL rnd_shadow: got %h expected %h", {poll_a, poll_b, poll_c},
                                 {ref_mem[0], ref_mem[1], ref_mem[2]});
                    end
                end
                ce_r = 1'($urandom_range(0, 1));
                step();
                lat++;
            end
            n_cmp++;
            if (ack !== 1'b1 || (idle0 && lat != 5)) begin
                n_err++;
                $display("FAIL rnd_ack op%0d: got ack=%b latency=%0d expected ack within 60 (5 from idle)",
                         i, ack, lat);
            end
            if (wr) begin
                if (ref_mem[ad] === 8'hxx || !(ad inside {wr_list})) wr_list.push_back(ad);
                ref_mem[ad] = dv;
                n_cmp++;
                if (mem[ad] !== dv) begin
                    n_err++;
                    $display("FAIL rnd_write op%0d: got reg%h=%h expected %h", i, ad, mem[ad], dv);
                end
            end else begin
                n_cmp++;
                if (rdata !== ref_mem[ad]) begin
                    n_err++;
                    $display("FAIL rnd_read op%0d: got reg%h=%h expected %h", i, ad, rdata, ref_mem[ad]);
                end
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                ce_r = 1'($urandom_range(0, 1));
                step();
            end
        end
        poll_en = 1'b0;
        bound = 0;
        while (busy && bound < 100) begin
            step();
            bound++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rnd_drain: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_second_req_ignored();
        test_autopoll();
        test_host_during_poll();
        test_reset_mid_strobe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
